// File: rtl/alu_probe_pkg.sv
// Shared command codes, display line map, line names and commit FSM states for alu_probe_bank.
// History-related entries are only used when ALU_PROBE_HISTORY_EN is defined.
package alu_probe_pkg;

    localparam int unsigned CMD_CTRL  = 0;
    localparam int unsigned CMD_SRC1  = 1;
    localparam int unsigned CMD_SRC2  = 2;
    localparam int unsigned CMD_EXEC  = 3;
    localparam int unsigned CMD_CLEAR = 4;

    localparam int unsigned LINE_SRC1      = 1;
    localparam int unsigned LINE_SRC2      = 2;
    localparam int unsigned LINE_CONTR     = 3;
    localparam int unsigned LINE_RESUL     = 4;
    localparam int unsigned LINE_COUNT     = 5;
    localparam int unsigned LINE_HIST_BASE = 6;

    localparam logic [39:0] NAME_SRC1  = "SRC_1";
    localparam logic [39:0] NAME_SRC2  = "SRC_2";
    localparam logic [39:0] NAME_CONTR = "CONTR";
    localparam logic [39:0] NAME_RESUL = "RESUL";
    localparam logic [39:0] NAME_COUNT = "COUNT";
    localparam logic [23:0] NAME_HIS   = "HIS";

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCommit
    } state_e;

    // Two ASCII decimal digits of a line index below 64.
    function automatic logic [15:0] dec2(input logic [5:0] k);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = k / 6'd10;
        ones = k % 6'd10;
        return {8'h30 + {2'b00, tens}, 8'h30 + {2'b00, ones}};
    endfunction

endpackage

// File: rtl/alu_probe_history.sv
// Ring buffer of committed {control, result} snapshots with an age-indexed combinational read port.
// Age 0 is the newest entry; CLEAR resets pointer and count but leaves the RAM contents alone.
module alu_probe_history
    import alu_probe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned HIST_DEPTH = 8,
    localparam int unsigned PTR_W     = $clog2(HIST_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [CTRL_W-1:0] wr_ctrl,
    input  logic [DATA_W-1:0] wr_result,
    input  logic [PTR_W-1:0]  rd_age,
    output logic [CTRL_W-1:0] rd_ctrl,
    output logic [DATA_W-1:0] rd_result,
    output logic [CNT_W-1:0]  count
);

    logic [CTRL_W+DATA_W-1:0] mem [HIST_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic [PTR_W-1:0]         rd_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (count_q != CNT_W'(HIST_DEPTH)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr_q] <= {wr_ctrl, wr_result};
        end
    end

    // Power-of-two depth makes the pointer arithmetic wrap naturally.
    assign rd_idx               = wr_ptr_q - PTR_W'(1) - rd_age;
    assign {rd_ctrl, rd_result} = mem[rd_idx];
    assign count                = count_q;

endmodule

// File: rtl/alu_probe_bank.sv
// ALU bring-up probe: operand/control registers loaded from the touch panel, registered LCD lines.
// Define ALU_PROBE_HISTORY_EN to add the EXEC/CLEAR commit FSM and the result history lines.
module alu_probe_bank
    import alu_probe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned HIST_DEPTH = 8,
    parameter int unsigned SEL_W      = 3,
    localparam int unsigned CNT_W     = $clog2(HIST_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  input_sel,
    input  logic              input_valid,
    input  logic [31:0]       input_value,
    input  logic [5:0]        display_number,
    output logic              display_valid,
    output logic [39:0]       display_name,
    output logic [31:0]       display_value,
    output logic [CTRL_W-1:0] alu_control,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic [CNT_W-1:0]  hist_count
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] src1_q, src2_q;
    logic              load_ok;
    logic              line_valid;
    logic [39:0]       line_name;
    logic [31:0]       line_value;

    // Loads are dropped while a commit is in flight so the snapshot stays consistent.
    assign load_ok = input_valid && !busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            src1_q <= '0;
            src2_q <= '0;
        end else if (load_ok) begin
            if (input_sel == SEL_W'(CMD_CTRL)) ctrl_q <= input_value[CTRL_W-1:0];
            if (input_sel == SEL_W'(CMD_SRC1)) src1_q <= input_value[DATA_W-1:0];
            if (input_sel == SEL_W'(CMD_SRC2)) src2_q <= input_value[DATA_W-1:0];
        end
    end

    assign alu_control = ctrl_q;
    assign alu_src1    = src1_q;
    assign alu_src2    = src2_q;

`ifdef ALU_PROBE_HISTORY_EN
    localparam int unsigned PTR_W = $clog2(HIST_DEPTH);

    state_e            state_q, state_d;
    logic              cmd_exec, cmd_clear, hist_wr;
    logic [5:0]        hist_k;
    logic [PTR_W-1:0]  hist_age;
    logic [DATA_W-1:0] hist_result;
    logic [CTRL_W-1:0] unused_hist_ctrl;

    assign cmd_exec  = input_valid && (input_sel == SEL_W'(CMD_EXEC));
    assign cmd_clear = input_valid && (input_sel == SEL_W'(CMD_CLEAR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        hist_wr = 1'b0;
        if (cmd_clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (cmd_exec) state_d = StSettle;
                StSettle: state_d = StCommit;
                StCommit: begin
                    state_d = StIdle;
                    hist_wr = 1'b1;
                end
                default:  state_d = StIdle;
            endcase
        end
    end

    assign busy     = (state_q != StIdle);
    assign hist_k   = display_number - 6'(LINE_HIST_BASE);
    assign hist_age = hist_k[PTR_W-1:0];

    alu_probe_history #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_history (
        .clk       (clk),
        .reset     (reset),
        .clear     (cmd_clear),
        .wr_en     (hist_wr),
        .wr_ctrl   (ctrl_q),
        .wr_result (alu_result),
        .rd_age    (hist_age),
        .rd_ctrl   (unused_hist_ctrl),
        .rd_result (hist_result),
        .count     (hist_count)
    );
`else
    assign busy       = 1'b0;
    assign hist_count = '0;
`endif

    always_comb begin
        line_valid = 1'b0;
        line_name  = '0;
        line_value = '0;
        case (display_number)
            6'(LINE_SRC1): begin
                line_valid = 1'b1;
                line_name  = NAME_SRC1;
                line_value = 32'(src1_q);
            end
            6'(LINE_SRC2): begin
                line_valid = 1'b1;
                line_name  = NAME_SRC2;
                line_value = 32'(src2_q);
            end
            6'(LINE_CONTR): begin
                line_valid = 1'b1;
                line_name  = NAME_CONTR;
                line_value = 32'(ctrl_q);
            end
            6'(LINE_RESUL): begin
                line_valid = 1'b1;
                line_name  = NAME_RESUL;
                line_value = 32'(alu_result);
            end
`ifdef ALU_PROBE_HISTORY_EN
            6'(LINE_COUNT): begin
                line_valid = 1'b1;
                line_name  = NAME_COUNT;
                line_value = 32'(hist_count);
            end
            default: begin
                if (display_number >= 6'(LINE_HIST_BASE) && int'(hist_k) < int'(HIST_DEPTH)
                    && int'(hist_k) < int'(hist_count)) begin
                    line_valid = 1'b1;
                    line_name  = {NAME_HIS, dec2(hist_k)};
                    line_value = 32'(hist_result);
                end
            end
`else
            default: ;
`endif
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_valid <= 1'b0;
            display_name  <= '0;
            display_value <= '0;
        end else begin
            display_valid <= line_valid;
            display_name  <= line_name;
            display_value <= line_value;
        end
    end

endmodule
